vivado_system_tb: RTL and testbench
===================================

Name: vivado_system_tb

Overview:
- Self-contained UART loopback system for simulation-based flow checking of exported IP-integrator designs.
- A pattern generator streams a synthetic sample image, byte by byte, through a UART transmitter.
- A UART receiver on the looped-back serial line checks every byte against the expected pattern and raises sim_done once the whole image has been received.
- Top of the exported block design; the enclosing test case supplies clock and reset and waits on sim_done.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be >= 4.
- IMG_W, 8, image width in pixels (bytes).
- IMG_H, 8, image height in rows.
- SEED, 8'h00, value of pixel 0.
- STEP, 8'h01, increment between consecutive pixels.

Ports:
- clk  input  1  system clock (200 MHz nominal, 5 ns period).
- rst_n  input  1  asynchronous active-low reset.
- uart_txd  output  1  serial line driven by the transmitter; idles high.
- uart_rxd  input  1  serial line into the receiver; connected externally to uart_txd.
- sim_done  output  1  high when all IMG_W*IMG_H bytes have been received; sticky.
- err_cnt  output  16  count of received bytes that mismatch the expected pixel, or have a bad stop bit.
- rx_cnt  output  16  count of bytes received.

Behaviour:
- Reset (asynchronous, rst_n=0) forces: uart_txd=1, sim_done=0, err_cnt=0, rx_cnt=0, both FSMs to IDLE, pixel indices to 0.
- Image size N = IMG_W*IMG_H. Pixel k = (SEED + k*STEP) mod 256, k = 0..N-1, row-major order.
- Frame format: 8N1, LSB first. One start bit (0), 8 data bits, one stop bit (1). Each bit is held exactly CLKS_PER_BIT cycles.
- TX FSM states:
  - IDLE: after reset release, wait 2 cycles, then LOAD.
  - LOAD: latch pixel k.
  - START, DATA (8 bits), STOP.
  - GAP: one idle bit time, line high.
  - Back to LOAD while k < N-1, incrementing k. After pixel N-1's STOP, go to DONE.
  - DONE: line high until reset.
- RX sampling:
  - Input is synchronised with a 2-flop synchroniser.
  - A falling edge in IDLE starts a frame.
  - The start bit is re-sampled at CLKS_PER_BIT/2 (integer division); if it reads high, it is a glitch and RX returns to IDLE.
  - Data bits are sampled every CLKS_PER_BIT cycles after the start midpoint; the stop bit is sampled one bit later.
- RX check, at the stop-bit sample:
  - rx_cnt increments.
  - Compare the data to expected pixel j, where j is the receive index.
  - If the data mismatches OR the stop bit is 0, err_cnt increments (saturating at 16'hFFFF).
  - j increments regardless of the check result.
- sim_done goes 1 on the cycle after rx_cnt reaches N. It stays 1 until reset and is never deasserted otherwise.
- Bytes arriving after N are counted in rx_cnt but are not checked.
- Reset mid-frame: both FSMs abort immediately; uart_txd returns high; on release the whole image restarts from pixel 0.
- Latency of the first byte: 2 cycles + 10*CLKS_PER_BIT to its stop sample, plus synchroniser delay (2 cycles).

Test Plan:
- Default parameters, rst_n low 10 ns then high, uart_rxd tied to uart_txd -> sim_done rises once. At that point rx_cnt=64, err_cnt=0; uart_txd stays high afterward.
- Probe uart_txd on the first frame -> start bit low for 16 cycles, then bits of 8'h00, then high stop. The second frame carries 8'h01, LSB first.
- Invert one data bit of frame 5 on uart_rxd (XOR window) -> final err_cnt=1, rx_cnt=64, sim_done=1.
- Force uart_rxd low during one stop bit -> err_cnt increments by 1 for that byte.
- Inject a 3-cycle low glitch on idle uart_rxd -> no byte counted; rx_cnt unchanged.
- Assert rst_n during frame 10, release -> counters 0, sim_done 0. Transmission restarts at 8'h00 and completes with err_cnt=0.

Source files
------------

// File: rtl/vivado_system_tb.sv
`timescale 1ns/1ps
// Loopback image checker: pattern generator drives an 8N1 UART TX, RX checks every byte against the expected pixel.
// Latency: first stop-bit sample about 2 + 10*CLKS_PER_BIT cycles after reset release, plus 2 cycles of sync.
// Backpressure: none; TX free-runs at line rate and RX samples whatever arrives.
module vivado_system_tb #(
  parameter int         CLKS_PER_BIT = 16,
  parameter int         IMG_W        = 8,
  parameter int         IMG_H        = 8,
  parameter logic [7:0] SEED         = 8'h00,
  parameter logic [7:0] STEP         = 8'h01
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        uart_txd,
  input  logic        uart_rxd,
  output logic        sim_done,
  output logic [15:0] err_cnt,
  output logic [15:0] rx_cnt
);

  localparam int              N         = IMG_W * IMG_H;
  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0]     N_CNT     = 16'(N);
  localparam logic [15:0]     K_LAST    = 16'(N - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_STOP, TX_GAP, TX_DONE} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  tx_state_t     tx_state, tx_state_nxt;
  logic [CW-1:0] tx_clk, tx_clk_nxt;
  logic [2:0]    tx_bit, tx_bit_nxt;
  logic [15:0]   tx_k, tx_k_nxt;
  logic [7:0]    tx_pix, tx_pix_nxt;
  logic [7:0]    tx_byte, tx_byte_nxt;
  logic          tx_line_nxt;
  logic          tx_bit_end;

  assign tx_bit_end = (tx_clk == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_clk   <= '0;
      tx_bit   <= '0;
      tx_k     <= '0;
      tx_pix   <= SEED;
      tx_byte  <= '0;
      uart_txd <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_clk   <= tx_clk_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_k     <= tx_k_nxt;
      tx_pix   <= tx_pix_nxt;
      tx_byte  <= tx_byte_nxt;
      uart_txd <= tx_line_nxt;
    end
  end

  always_comb begin
    tx_state_nxt = tx_state;
    tx_clk_nxt   = tx_clk;
    tx_bit_nxt   = tx_bit;
    tx_k_nxt     = tx_k;
    tx_pix_nxt   = tx_pix;
    tx_byte_nxt  = tx_byte;
    tx_line_nxt  = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (tx_clk == CW'(1)) begin
          tx_state_nxt = TX_LOAD;
          tx_clk_nxt   = '0;
        end else begin
          tx_clk_nxt = tx_clk + 1'b1;
        end
      end
      TX_LOAD: begin
        tx_byte_nxt  = tx_pix;
        tx_clk_nxt   = '0;
        tx_state_nxt = TX_START;
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_clk_nxt   = '0;
          tx_bit_nxt   = '0;
          tx_state_nxt = TX_DATA;
        end else begin
          tx_clk_nxt = tx_clk + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_clk_nxt = '0;
          if (tx_bit == 3'd7) tx_state_nxt = TX_STOP;
          else                tx_bit_nxt   = tx_bit + 1'b1;
        end else begin
          tx_clk_nxt = tx_clk + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_clk_nxt   = '0;
          tx_state_nxt = (tx_k == K_LAST) ? TX_DONE : TX_GAP;
        end else begin
          tx_clk_nxt = tx_clk + 1'b1;
        end
      end
      TX_GAP: begin
        if (tx_bit_end) begin
          tx_clk_nxt   = '0;
          tx_k_nxt     = tx_k + 1'b1;
          tx_pix_nxt   = tx_pix + STEP;
          tx_state_nxt = TX_LOAD;
        end else begin
          tx_clk_nxt = tx_clk + 1'b1;
        end
      end
      TX_DONE: tx_state_nxt = TX_DONE;
      default: tx_state_nxt = TX_IDLE;
    endcase
    // Line is registered off the next state so it changes in step with the state, glitch-free.
    case (tx_state_nxt)
      TX_START: tx_line_nxt = 1'b0;
      TX_DATA:  tx_line_nxt = tx_byte_nxt[tx_bit_nxt];
      default:  tx_line_nxt = 1'b1;
    endcase
  end

  logic [1:0]    rx_sync;
  logic          rx_prev;
  logic          rxd;
  rx_state_t     rx_state, rx_state_nxt;
  logic [CW-1:0] rx_clk, rx_clk_nxt;
  logic [2:0]    rx_bit, rx_bit_nxt;
  logic [7:0]    rx_shift, rx_shift_nxt;
  logic [15:0]   rx_j, rx_j_nxt;
  logic [7:0]    rx_exp, rx_exp_nxt;
  logic [15:0]   rx_cnt_nxt, err_cnt_nxt;
  logic          sim_done_nxt;
  logic          rx_stb;
  logic          byte_bad;

  assign rxd      = rx_sync[1];
  assign byte_bad = (rx_shift != rx_exp) || !rxd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync  <= 2'b11;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_clk   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_j     <= '0;
      rx_exp   <= SEED;
      rx_cnt   <= '0;
      err_cnt  <= '0;
      sim_done <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], uart_rxd};
      rx_prev  <= rxd;
      rx_state <= rx_state_nxt;
      rx_clk   <= rx_clk_nxt;
      rx_bit   <= rx_bit_nxt;
      rx_shift <= rx_shift_nxt;
      rx_j     <= rx_j_nxt;
      rx_exp   <= rx_exp_nxt;
      rx_cnt   <= rx_cnt_nxt;
      err_cnt  <= err_cnt_nxt;
      sim_done <= sim_done_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_clk_nxt   = rx_clk;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_j_nxt     = rx_j;
    rx_exp_nxt   = rx_exp;
    rx_cnt_nxt   = rx_cnt;
    err_cnt_nxt  = err_cnt;
    rx_stb       = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rxd) begin
          rx_clk_nxt   = '0;
          rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        // Mid-bit recheck rejects short low pulses on an idle line.
        if (rx_clk == HALF_LAST) begin
          rx_clk_nxt   = '0;
          rx_bit_nxt   = '0;
          rx_state_nxt = rxd ? RX_IDLE : RX_DATA;
        end else begin
          rx_clk_nxt = rx_clk + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_clk == BIT_LAST) begin
          rx_clk_nxt   = '0;
          rx_shift_nxt = {rxd, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
          else                rx_bit_nxt   = rx_bit + 1'b1;
        end else begin
          rx_clk_nxt = rx_clk + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_clk == BIT_LAST) begin
          rx_clk_nxt   = '0;
          rx_stb       = 1'b1;
          rx_state_nxt = RX_IDLE;
        end else begin
          rx_clk_nxt = rx_clk + 1'b1;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
    if (rx_stb) begin
      rx_cnt_nxt = rx_cnt + 1'b1;
      if (rx_j < N_CNT) begin
        rx_j_nxt   = rx_j + 1'b1;
        rx_exp_nxt = rx_exp + STEP;
        if (byte_bad && (err_cnt != 16'hFFFF)) err_cnt_nxt = err_cnt + 1'b1;
      end
    end
    sim_done_nxt = sim_done | (rx_cnt == N_CNT);
  end

endmodule

// File: tb/tb_vivado_system_tb.sv
`timescale 1ns/1ps
// Loopback bench: decodes uart_txd against a pixel scoreboard and disturbs uart_rxd to exercise the RX error paths.
module tb_vivado_system_tb;
  localparam int         CPB    = 16;
  localparam int         N      = 64;
  localparam logic [7:0] SEED   = 8'h00;
  localparam logic [7:0] STEP   = 8'h01;
  localparam int         BUDGET = 12 * CPB * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        corrupt = 1'b0;
  logic        force_low = 1'b0;
  logic        uart_txd, uart_rxd, sim_done;
  logic [15:0] err_cnt, rx_cnt;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];

  always #2.5 clk = ~clk;
  assign uart_rxd = force_low ? 1'b0 : (uart_txd ^ corrupt);

  vivado_system_tb #(.CLKS_PER_BIT(CPB), .IMG_W(8), .IMG_H(8), .SEED(SEED), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .uart_txd(uart_txd), .uart_rxd(uart_rxd),
    .sim_done(sim_done), .err_cnt(err_cnt), .rx_cnt(rx_cnt)
  );

  task automatic do_reset();
    corrupt = 1'b0; force_low = 1'b0;
    rst_n = 1'b0; #10; rst_n = 1'b1;
  endtask

  task automatic push_image();
    exp_q.delete();
    for (int k = 0; k < N; k++) exp_q.push_back(8'((int'(SEED) + k * int'(STEP)) % 256));
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < BUDGET && !found; i++) begin
      @(negedge clk);
      if (uart_txd === 1'b0) found = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (sim_done === 1'b1) found = 1'b1;
    end
  endtask

  // Samples each bit at its first and last cycle; a mismatch means a bit was not held CPB cycles.
  task automatic get_frame(output logic [7:0] d, output bit shape_ok, output logic stop_v, output bit found);
    logic s0, s1;
    d = '0; shape_ok = 1'b1; stop_v = 1'b0;
    wait_start(found);
    if (!found) return;
    for (int b = 0; b < 10; b++) begin
      if (b > 0) @(negedge clk);
      s0 = uart_txd;
      repeat (CPB - 1) @(negedge clk);
      s1 = uart_txd;
      if (s0 !== s1) shape_ok = 1'b0;
      if (b == 0 && s0 !== 1'b0) shape_ok = 1'b0;
      if (b >= 1 && b <= 8) d[b-1] = s0;
      if (b == 9) stop_v = s0;
    end
  endtask

  task automatic skip_frames(input int n);
    logic [7:0] d; bit sh; logic st; bit found;
    for (int f = 0; f < n; f++) begin
      get_frame(d, sh, st, found);
      checks++;
      if (!found) begin failures++; $display("FAIL skip_frame%0d timeout got=none exp=start", f); return; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; #12;
    checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b exp=1", uart_txd); end
    checks++; if (sim_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", sim_done); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
    checks++; if (rx_cnt !== 16'd0) begin failures++; $display("FAIL reset_rx got=%0d exp=0", rx_cnt); end
  endtask

  task automatic test_full_image();
    logic [7:0] d, exp_b; bit sh, found; logic st; int lows;
    do_reset(); push_image();
    for (int f = 0; f < N; f++) begin
      if (f == N - 1) begin
        checks++; if (sim_done !== 1'b0) begin failures++; $display("FAIL early_done got=%b exp=0", sim_done); end
      end
      get_frame(d, sh, st, found);
      checks++;
      if (!found) begin failures++; $display("FAIL frame%0d_timeout got=none exp=start", f); break; end
      exp_b = exp_q.pop_front();
      checks++; if (d !== exp_b) begin failures++; $display("FAIL frame%0d_data got=%h exp=%h", f, d, exp_b); end
      checks++; if (sh !== 1'b1) begin failures++; $display("FAIL frame%0d_shape got=%b exp=1", f, sh); end
      checks++; if (st !== 1'b1) begin failures++; $display("FAIL frame%0d_stop got=%b exp=1", f, st); end
    end
    wait_done(8 * CPB, found);
    checks++; if (!found) begin failures++; $display("FAIL full_done got=%b exp=1", sim_done); end
    checks++; if (rx_cnt !== 16'd64) begin failures++; $display("FAIL full_rx got=%0d exp=64", rx_cnt); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL full_err got=%0d exp=0", err_cnt); end
    lows = 0;
    for (int i = 0; i < 33 * CPB; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || sim_done !== 1'b1) lows++;
    end
    checks++; if (lows !== 0) begin failures++; $display("FAIL idle_after_done got=%0d exp=0", lows); end
  endtask

  task automatic test_data_corrupt();
    bit found;
    do_reset();
    skip_frames(5);
    wait_start(found);
    checks++; if (!found) begin failures++; $display("FAIL corrupt_start got=none exp=start"); end
    repeat (3 * CPB) @(negedge clk);
    corrupt = 1'b1;
    repeat (CPB) @(negedge clk);
    corrupt = 1'b0;
    wait_done(N * 12 * CPB, found);
    checks++; if (!found) begin failures++; $display("FAIL corrupt_done got=%b exp=1", sim_done); end
    checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL corrupt_err got=%0d exp=1", err_cnt); end
    checks++; if (rx_cnt !== 16'd64) begin failures++; $display("FAIL corrupt_rx got=%0d exp=64", rx_cnt); end
  endtask

  task automatic test_stop_error();
    bit found;
    do_reset();
    skip_frames(3);
    wait_start(found);
    checks++; if (!found) begin failures++; $display("FAIL stop_start got=none exp=start"); end
    repeat (9 * CPB) @(negedge clk);
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL stop_err_before got=%0d exp=0", err_cnt); end
    force_low = 1'b1;
    repeat (CPB) @(negedge clk);
    force_low = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL stop_err_after got=%0d exp=1", err_cnt); end
    checks++; if (rx_cnt !== 16'd4) begin failures++; $display("FAIL stop_rx_after got=%0d exp=4", rx_cnt); end
    wait_done(N * 12 * CPB, found);
    checks++; if (!found) begin failures++; $display("FAIL stop_done got=%b exp=1", sim_done); end
    checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL stop_err_final got=%0d exp=1", err_cnt); end
  endtask

  // Runs on the finished image left by test_stop_error: 64 received, one error.
  task automatic test_idle_glitch();
    @(negedge clk);
    force_low = 1'b1;
    repeat (3) @(negedge clk);
    force_low = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    checks++; if (rx_cnt !== 16'd64) begin failures++; $display("FAIL glitch_rx got=%0d exp=64", rx_cnt); end
    checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL glitch_err got=%0d exp=1", err_cnt); end
    checks++; if (sim_done !== 1'b1) begin failures++; $display("FAIL glitch_done got=%b exp=1", sim_done); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d, exp_b; bit sh, found; logic st;
    do_reset();
    skip_frames(10);
    wait_start(found);
    checks++; if (!found) begin failures++; $display("FAIL mid_start got=none exp=start"); end
    repeat (4 * CPB) @(negedge clk);
    rst_n = 1'b0; #1;
    checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL mid_txd got=%b exp=1", uart_txd); end
    checks++; if (rx_cnt !== 16'd0) begin failures++; $display("FAIL mid_rx got=%0d exp=0", rx_cnt); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL mid_err got=%0d exp=0", err_cnt); end
    checks++; if (sim_done !== 1'b0) begin failures++; $display("FAIL mid_done got=%b exp=0", sim_done); end
    #9; rst_n = 1'b1;
    push_image();
    for (int f = 0; f < N; f++) begin
      get_frame(d, sh, st, found);
      checks++;
      if (!found) begin failures++; $display("FAIL mid_frame%0d_timeout got=none exp=start", f); break; end
      exp_b = exp_q.pop_front();
      checks++; if (d !== exp_b) begin failures++; $display("FAIL mid_frame%0d_data got=%h exp=%h", f, d, exp_b); end
    end
    wait_done(8 * CPB, found);
    checks++; if (!found) begin failures++; $display("FAIL mid_final_done got=%b exp=1", sim_done); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL mid_final_err got=%0d exp=0", err_cnt); end
    checks++; if (rx_cnt !== 16'd64) begin failures++; $display("FAIL mid_final_rx got=%0d exp=64", rx_cnt); end
  endtask

  initial begin
    test_reset();
    test_full_image();
    test_data_corrupt();
    test_stop_error();
    test_idle_glitch();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
